wb_arbiter: RTL and testbench

- Write-back arbiter that drives the single write port (we/waddr/wdata) of the 32x32 register file.
- Merges two result sources:
  - single-cycle ALU results, which are always accepted and have priority;
  - variable-latency load results, which are buffered in a small FIFO.
- Enforces the $zero rule upstream of the register file and resolves WAW conflicts between pending loads and newer ALU writes.

---
 rtl/wb_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_wb_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - write-back arbiter merging ALU and buffered load results onto the register file write port
// Optional feature macro: WB_STARVE_GUARD_EN (periodically stalls the ALU so a starved load can drain)

module wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_waddr,
    input  logic [DATA_W-1:0]          alu_wdata,
    output logic                       alu_stall,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [ADDR_W-1:0]          ld_waddr,
    input  logic [DATA_W-1:0]          ld_wdata,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Elaboration-time parameter sanity: pointer wrap relies on a power-of-2 depth
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_MAX < 1) begin : g_param_check
        $error("wb_arbiter: DEPTH must be a power of 2 >= 2 and STARVE_MAX >= 1");
    end

    // Load FIFO storage: kill bits are reset, payload is not
    logic [DEPTH-1:0]  r_kill;
    logic [ADDR_W-1:0] r_waddr_q [DEPTH];
    logic [DATA_W-1:0] r_wdata_q [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Registered write port
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;

    logic              w_alu_stall;
    logic              w_ld_ready;
    logic              w_nonempty;
    logic              w_alu_grant;
    logic              w_pop;
    logic              w_push;
    logic              w_kill_en;
    logic              w_push_kill;
    logic              w_head_kill;
    logic [ADDR_W-1:0] w_head_waddr;
    logic [DATA_W-1:0] w_head_wdata;
    logic [DEPTH-1:0]  w_entry_valid;
    logic [DEPTH-1:0]  w_kill_hit;

    assign w_ld_ready  = (r_count < CNT_W'(DEPTH));
    assign w_nonempty  = (r_count != '0);

    // ALU has priority unless the starvation guard is forcing a pop this cycle
    assign w_alu_grant = alu_valid && !w_alu_stall;
    assign w_pop       = !w_alu_grant && w_nonempty;
    assign w_push      = ld_valid && w_ld_ready;

    // A newer nonzero ALU write supersedes any pending load to the same register,
    // including a load arriving in this same cycle (treated as older)
    assign w_kill_en   = w_alu_grant && (alu_waddr != '0);
    assign w_push_kill = w_kill_en && (ld_waddr == alu_waddr);

    assign w_head_kill  = r_kill[r_rd_ptr];
    assign w_head_waddr = r_waddr_q[r_rd_ptr];
    assign w_head_wdata = r_wdata_q[r_rd_ptr];

    // Mark occupied slots (distance from head below count) and those hit by the ALU write
    always_comb begin
        w_entry_valid = '0;
        w_kill_hit    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_entry_valid[i] = (CNT_W'(PTR_W'(PTR_W'(i) - r_rd_ptr)) < r_count);
            w_kill_hit[i]    = w_kill_en && w_entry_valid[i] && (r_waddr_q[i] == alu_waddr);
        end
    end

    // Kill bits: a fresh push overwrites the slot's bit, otherwise matches get set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kill <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (r_wr_ptr == PTR_W'(i))) begin
                    r_kill[i] <= w_push_kill;
                end else if (w_kill_hit[i]) begin
                    r_kill[i] <= 1'b1;
                end
            end
        end
    end

    // Load payload capture on push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_waddr_q[r_wr_ptr] <= ld_waddr;
            r_wdata_q[r_wr_ptr] <= ld_wdata;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Write port register: ALU grant, head pop, or idle (address/data held)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else if (w_alu_grant) begin
            r_rf_we    <= (alu_waddr != '0);
            r_rf_waddr <= alu_waddr;
            r_rf_wdata <= alu_wdata;
        end else if (w_pop) begin
            r_rf_we    <= !w_head_kill && (w_head_waddr != '0);
            r_rf_waddr <= w_head_waddr;
            r_rf_wdata <= w_head_wdata;
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

`ifdef WB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_MAX + 1);

    logic [SC_W-1:0] r_starve_cnt;
    logic            r_alu_stall;

    // Count ALU wins over a waiting load; the STARVE_MAX-th win schedules a one-cycle stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
            r_alu_stall  <= 1'b0;
        end else begin
            r_alu_stall <= w_alu_grant && w_nonempty && (r_starve_cnt == SC_W'(STARVE_MAX - 1));
            if (w_pop || !w_nonempty) begin
                r_starve_cnt <= '0;
            end else if (w_alu_grant) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    assign w_alu_stall = r_alu_stall;
`else
    assign w_alu_stall = 1'b0;
`endif

    assign alu_stall  = w_alu_stall;
    assign ld_ready   = w_ld_ready;
    assign fifo_count = r_count;
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter against a queue-based reference model

module tb_wb_arbiter;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        alu_stall;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_waddr;
    logic [31:0] ld_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  fifo_count;

    wb_arbiter #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5), .STARVE_MAX(STARVE_MAX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_waddr  (alu_waddr),
        .alu_wdata  (alu_wdata),
        .alu_stall  (alu_stall),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_waddr   (ld_waddr),
        .ld_wdata   (ld_wdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        kill;
        bit [4:0]  a;
        bit [31:0] d;
    } ent_t;

    ent_t      mq[$];
    bit        m_we;
    bit [4:0]  m_addr;
    bit [31:0] m_data;
    bit        m_stall;
    int        m_cnt;
    bit        m_pushed;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_we     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
        m_stall  = 1'b0;
        m_cnt    = 0;
        m_pushed = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rf_we"},      {31'd0, rf_we},      {31'd0, m_we});
        chk({tag, ".rf_waddr"},   {27'd0, rf_waddr},   {27'd0, m_addr});
        chk({tag, ".rf_wdata"},   rf_wdata,            m_data);
        chk({tag, ".fifo_count"}, {29'd0, fifo_count}, mq.size());
        chk({tag, ".ld_ready"},   {31'd0, ld_ready},   {31'd0, mq.size() < DEPTH});
        chk({tag, ".alu_stall"},  {31'd0, alu_stall},  {31'd0, m_stall});
    endtask

    // Apply one clock of the arbitration rules to the model, then clock the DUT and compare
    task automatic step(input string tag);
        bit   rdy, grant, ne, pop, push, nstall;
        ent_t h, e;
        rdy   = mq.size() < DEPTH;
        ne    = mq.size() != 0;
        grant = alu_valid && !m_stall;
        pop   = !grant && ne;
        push  = ld_valid && rdy;
        if (grant) begin
            m_we   = alu_waddr != 0;
            m_addr = alu_waddr;
            m_data = alu_wdata;
            if (alu_waddr != 0)
                foreach (mq[i]) if (mq[i].a == alu_waddr) mq[i].kill = 1'b1;
        end else if (pop) begin
            h      = mq.pop_front();
            m_we   = !h.kill && h.a != 0;
            m_addr = h.a;
            m_data = h.d;
        end else begin
            m_we = 1'b0;
        end
        if (push) begin
            e.kill = grant && alu_waddr != 0 && ld_waddr == alu_waddr;
            e.a    = ld_waddr;
            e.d    = ld_wdata;
            mq.push_back(e);
        end
        m_pushed = push;
`ifdef WB_STARVE_GUARD_EN
        nstall = grant && ne && (m_cnt + 1 == STARVE_MAX);
        if (pop || !ne) m_cnt = 0;
        else if (grant) m_cnt++;
        m_stall = nstall;
`else
        nstall  = 1'b0;
        m_stall = nstall;
`endif
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_waddr = '0;
        alu_wdata = '0;
        ld_valid  = 1'b0;
        ld_waddr  = '0;
        ld_wdata  = '0;
    endtask

    int stall_seen;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #12;
        chk("reset.rf_we",      {31'd0, rf_we},      32'd0);
        chk("reset.rf_waddr",   {27'd0, rf_waddr},   32'd0);
        chk("reset.rf_wdata",   rf_wdata,            32'd0);
        chk("reset.fifo_count", {29'd0, fifo_count}, 32'd0);
        chk("reset.ld_ready",   {31'd0, ld_ready},   32'd1);
        chk("reset.alu_stall",  {31'd0, alu_stall},  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("idle0");

        // ALU only, nonzero then zero destination
        alu_valid = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'hDEADBEEF;
        step("alu3");
        chk("alu3.we",   {31'd0, rf_we},    32'd1);
        chk("alu3.addr", {27'd0, rf_waddr}, 32'd3);
        chk("alu3.data", rf_wdata,          32'hDEADBEEF);
        alu_waddr = 5'd0;
        step("alu0");
        chk("alu0.we", {31'd0, rf_we}, 32'd0);
        idle_inputs();

        // Load into an idle arbiter
        ld_valid = 1'b1; ld_waddr = 5'd7; ld_wdata = 32'h12345678;
        step("ld_push");
        chk("ld_push.count", {29'd0, fifo_count}, 32'd1);
        idle_inputs();
        step("ld_pop");
        chk("ld_pop.we",    {31'd0, rf_we},      32'd1);
        chk("ld_pop.addr",  {27'd0, rf_waddr},   32'd7);
        chk("ld_pop.data",  rf_wdata,            32'h12345678);
        chk("ld_pop.count", {29'd0, fifo_count}, 32'd0);

        // Fill behind continuous ALU traffic, then drain in order
        for (int i = 1; i <= 4; i++) begin
            alu_valid = 1'b1; alu_waddr = 5'd8; alu_wdata = 32'h100 + i;
            ld_valid  = 1'b1; ld_waddr  = 5'(i); ld_wdata = 32'hA000 + i;
            step("fill");
        end
        chk("full.count", {29'd0, fifo_count}, 32'd4);
        chk("full.ready", {31'd0, ld_ready},   32'd0);
        alu_valid = 1'b0;
        ld_valid  = 1'b1; ld_waddr = 5'd6; ld_wdata = 32'hBAD0;
        step("drain1");
        chk("drain1.addr",  {27'd0, rf_waddr},   32'd1);
        chk("drain1.count", {29'd0, fifo_count}, 32'd3);
        chk("drain1.ready", {31'd0, ld_ready},   32'd1);
        ld_valid = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            step("drain");
            chk("drain.we",   {31'd0, rf_we},    32'd1);
            chk("drain.addr", {27'd0, rf_waddr}, 32'(i));
            chk("drain.data", rf_wdata,          32'hA000 + i);
        end
        idle_inputs();
        step("idle1");

        // WAW: buffered load killed by a newer ALU write
        alu_valid = 1'b1; alu_waddr = 5'd9; alu_wdata = 32'h1;
        ld_valid  = 1'b1; ld_waddr  = 5'd5; ld_wdata = 32'hAAAA;
        step("waw_push");
        ld_valid = 1'b0;
        alu_waddr = 5'd5; alu_wdata = 32'hBBBB;
        step("waw_alu");
        chk("waw_alu.data", rf_wdata, 32'hBBBB);
        alu_valid = 1'b0;
        step("waw_pop");
        chk("waw_pop.we", {31'd0, rf_we}, 32'd0);

        // WAW with the load arriving in the same cycle as the ALU write
        alu_valid = 1'b1; alu_waddr = 5'd6; alu_wdata = 32'hCCCC;
        ld_valid  = 1'b1; ld_waddr  = 5'd6; ld_wdata = 32'hDDDD;
        step("waw_same");
        idle_inputs();
        step("waw_same_pop");
        chk("waw_same_pop.we", {31'd0, rf_we}, 32'd0);

        // Load to register 0 is never written
        ld_valid = 1'b1; ld_waddr = 5'd0; ld_wdata = 32'h5555;
        step("ld0_push");
        idle_inputs();
        step("ld0_pop");
        chk("ld0_pop.we", {31'd0, rf_we}, 32'd0);

`ifdef WB_STARVE_GUARD_EN
        // Starvation guard: one waiting load behind a steady ALU stream
        alu_valid = 1'b1; alu_waddr = 5'd10; alu_wdata = 32'h77;
        ld_valid  = 1'b1; ld_waddr  = 5'd11; ld_wdata = 32'h88;
        step("starve_push");
        ld_valid = 1'b0;
        stall_seen = 0;
        for (int i = 0; i < STARVE_MAX + 3; i++) begin
            step("starve");
            if (alu_stall) stall_seen++;
        end
        chk("starve.stalls", stall_seen, 32'd1);
        idle_inputs();
        step("idle2");
`else
        stall_seen = 0;
`endif

        // Reset mid-operation with three loads buffered
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_waddr = 5'd12; alu_wdata = 32'h200 + i;
            ld_valid  = 1'b1; ld_waddr  = 5'(13 + i); ld_wdata = 32'h300 + i;
            step("pre_rst");
        end
        chk("pre_rst.count", {29'd0, fifo_count}, 32'd3);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst.we",    {31'd0, rf_we},      32'd0);
        chk("mid_rst.count", {29'd0, fifo_count}, 32'd0);
        chk("mid_rst.ready", {31'd0, ld_ready},   32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step("post_rst");
            chk("post_rst.we", {31'd0, rf_we}, 32'd0);
        end

        // Randomized traffic; sources hold a stalled ALU result and an unaccepted load
        for (int n = 0; n < 400; n++) begin
            if (!(alu_valid && alu_stall)) begin
                alu_valid = ($urandom_range(0, 9) < 6);
                alu_waddr = 5'($urandom_range(0, 7));
                alu_wdata = $urandom;
            end
            if (!(ld_valid && !m_pushed)) begin
                ld_valid = ($urandom_range(0, 9) < 5);
                ld_waddr = 5'($urandom_range(0, 7));
                ld_wdata = $urandom;
            end
            step("rand");
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) step("flush");
        chk("flush.count", {29'd0, fifo_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
